// File: rtl/tlb_pkg.sv
// Shared types and helpers for the fully associative TLB.
// ASID width is carried at ASID_MAX_W; builds without TLB_ASID_EN tie the field to zero.
package tlb_pkg;

    localparam int unsigned PERM_W     = 7;
    localparam int unsigned VPN_W      = 20;
    localparam int unsigned PPN_W      = 22;
    localparam int unsigned ASID_MAX_W = 16;
    localparam int unsigned SP_LSB     = 10;

    typedef struct packed {
        logic                  valid;
        logic [VPN_W-1:0]      vpn;
        logic [PPN_W-1:0]      ppn;
        logic [PERM_W-1:0]     perm;
        logic                  superpage;
        logic                  is_global;
        logic [ASID_MAX_W-1:0] asid;
    } tlb_entry_t;

    // Superpages only compare the upper VPN bits.
    function automatic logic vpn_eq(input logic sp, input logic [VPN_W-1:0] a,
                                    input logic [VPN_W-1:0] b);
        if (sp) begin
            return a[VPN_W-1:SP_LSB] == b[VPN_W-1:SP_LSB];
        end
        return a == b;
    endfunction

endpackage

// File: rtl/tlb_victim_sel.sv
// Fill slot selection: existing match, else lowest invalid entry, else round-robin pointer.
module tlb_victim_sel
    import tlb_pkg::*;
#(
    parameter int unsigned ENTRIES = 32,
    parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fill_en_i,
    input  logic [ENTRIES-1:0] valid_i,
    input  logic [ENTRIES-1:0] match_i,
    output logic [IDX_W-1:0]   slot_o
);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             use_ptr;

    always_comb begin
        slot_o  = ptr_q;
        use_ptr = 1'b1;
        for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
            if (!valid_i[i]) begin
                slot_o  = IDX_W'(i);
                use_ptr = 1'b0;
            end
        end
        for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
            if (match_i[i]) begin
                slot_o  = IDX_W'(i);
                use_ptr = 1'b0;
            end
        end
    end

    // ENTRIES is a power of two, so the pointer wraps naturally.
    always_comb begin
        ptr_d = ptr_q;
        if (fill_en_i && use_ptr) begin
            ptr_d = ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/tlb_assoc.sv
// Fully associative TLB with registered lookup, fill and SFENCE.VMA-style flush.
// Define TLB_ASID_EN to enable ASID storage and ASID-qualified compare/flush.
module tlb_assoc
    import tlb_pkg::*;
#(
    parameter int unsigned ENTRIES = 32,
    parameter int unsigned ASID_W  = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lookup_req_i,
    input  logic [31:0]       vaddr_i,
    input  logic [ASID_W-1:0] asid_i,
    output logic              lookup_valid_o,
    output logic              hit_o,
    output logic [31:0]       paddr_o,
    output logic [PERM_W-1:0] perm_o,
    output logic              is_superpage_o,
    input  logic              fill_req_i,
    input  logic [VPN_W-1:0]  fill_vpn_i,
    input  logic [PPN_W-1:0]  fill_ppn_i,
    input  logic [PERM_W-1:0] fill_perm_i,
    input  logic              fill_superpage_i,
    input  logic              fill_global_i,
    input  logic [ASID_W-1:0] fill_asid_i,
    input  logic              flush_all_i,
    input  logic              flush_vpn_i,
    input  logic              flush_asid_i,
    input  logic [VPN_W-1:0]  flush_vpn_addr_i,
    input  logic [ASID_W-1:0] flush_asid_addr_i
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);

    tlb_entry_t         entries_q [ENTRIES];
    tlb_entry_t         lk_e, new_entry;
    logic               lk_hit;
    logic [ENTRIES-1:0] valid_vec, fill_match, flush_hit;
    logic [IDX_W-1:0]   fill_slot;
    logic               flush_any, fill_en;
    logic [VPN_W-1:0]   lk_vpn;
    logic               unused_tlb;

    assign flush_any = flush_all_i | flush_vpn_i | flush_asid_i;
    assign fill_en   = fill_req_i & ~flush_any;
    assign lk_vpn    = vaddr_i[31:12];

`ifdef TLB_ASID_EN
    logic [ASID_MAX_W-1:0] lk_asid, fill_asid, flush_asid;
    assign lk_asid    = ASID_MAX_W'(asid_i);
    assign fill_asid  = ASID_MAX_W'(fill_asid_i);
    assign flush_asid = ASID_MAX_W'(flush_asid_addr_i);
`endif

    always_comb begin
        lk_hit     = 1'b0;
        lk_e       = '0;
        valid_vec  = '0;
        fill_match = '0;
        flush_hit  = '0;
        unused_tlb = 1'b0;
        for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
            valid_vec[i] = entries_q[i].valid;
            unused_tlb   = unused_tlb ^ (^{entries_q[i].ppn[PPN_W-1:VPN_W],
                                           entries_q[i].asid, entries_q[i].is_global});
`ifdef TLB_ASID_EN
            if (entries_q[i].valid
                && (entries_q[i].is_global || entries_q[i].asid == lk_asid)
                && vpn_eq(entries_q[i].superpage, entries_q[i].vpn, lk_vpn)) begin
                lk_hit = 1'b1;
                lk_e   = entries_q[i];
            end
            fill_match[i] = entries_q[i].valid
                && entries_q[i].superpage == fill_superpage_i
                && vpn_eq(fill_superpage_i, entries_q[i].vpn, fill_vpn_i)
                && entries_q[i].is_global == fill_global_i
                && (fill_global_i || entries_q[i].asid == fill_asid);
            if (flush_all_i) begin
                flush_hit[i] = 1'b1;
            end else if (flush_vpn_i && flush_asid_i) begin
                flush_hit[i] = !entries_q[i].is_global && entries_q[i].asid == flush_asid
                    && vpn_eq(entries_q[i].superpage, entries_q[i].vpn, flush_vpn_addr_i);
            end else if (flush_vpn_i) begin
                flush_hit[i] = vpn_eq(entries_q[i].superpage, entries_q[i].vpn,
                                      flush_vpn_addr_i);
            end else if (flush_asid_i) begin
                flush_hit[i] = !entries_q[i].is_global && entries_q[i].asid == flush_asid;
            end
`else
            if (entries_q[i].valid
                && vpn_eq(entries_q[i].superpage, entries_q[i].vpn, lk_vpn)) begin
                lk_hit = 1'b1;
                lk_e   = entries_q[i];
            end
            fill_match[i] = entries_q[i].valid
                && entries_q[i].superpage == fill_superpage_i
                && vpn_eq(fill_superpage_i, entries_q[i].vpn, fill_vpn_i);
            // Without ASIDs everything is global: a bare ASID flush empties the TLB.
            if (flush_all_i || (flush_asid_i && !flush_vpn_i)) begin
                flush_hit[i] = 1'b1;
            end else if (flush_vpn_i) begin
                flush_hit[i] = vpn_eq(entries_q[i].superpage, entries_q[i].vpn,
                                      flush_vpn_addr_i);
            end
`endif
        end
`ifndef TLB_ASID_EN
        unused_tlb = unused_tlb ^ (^{asid_i, fill_asid_i, fill_global_i, flush_asid_addr_i});
`endif
    end

    always_comb begin
        new_entry           = '0;
        new_entry.valid     = 1'b1;
        new_entry.vpn       = fill_vpn_i;
        new_entry.ppn       = fill_ppn_i;
        new_entry.perm      = fill_perm_i;
        new_entry.superpage = fill_superpage_i;
`ifdef TLB_ASID_EN
        new_entry.is_global = fill_global_i;
        new_entry.asid      = fill_asid;
`else
        new_entry.is_global = 1'b1;
`endif
    end

    tlb_victim_sel #(
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W)
    ) u_victim_sel (
        .clk       (clk),
        .rst       (rst),
        .fill_en_i (fill_en),
        .valid_i   (valid_vec),
        .match_i   (fill_match),
        .slot_o    (fill_slot)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entries_q <= '{default: '0};
        end else begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                if (flush_hit[i]) begin
                    entries_q[i].valid <= 1'b0;
                end
            end
            if (fill_en) begin
                entries_q[fill_slot] <= new_entry;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lookup_valid_o <= 1'b0;
            hit_o          <= 1'b0;
            paddr_o        <= '0;
            perm_o         <= '0;
            is_superpage_o <= 1'b0;
        end else begin
            lookup_valid_o <= lookup_req_i;
            if (lookup_req_i) begin
                hit_o          <= lk_hit;
                perm_o         <= lk_e.perm;
                is_superpage_o <= lk_e.superpage;
                if (!lk_hit) begin
                    paddr_o <= '0;
                end else if (lk_e.superpage) begin
                    paddr_o <= {lk_e.ppn[VPN_W-1:SP_LSB], vaddr_i[21:0]};
                end else begin
                    paddr_o <= {lk_e.ppn[VPN_W-1:0], vaddr_i[11:0]};
                end
            end
        end
    end

endmodule

// File: tb/tb_tlb_assoc.sv
// Directed bench for tlb_assoc: lookup table plus fill/flush/reset sequences.
module tb_tlb_assoc;

`ifdef TLB_ASID_EN
    localparam bit ASID_EN = 1'b1;
`else
    localparam bit ASID_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        lookup_req_i;
    logic [31:0] vaddr_i;
    logic [8:0]  asid_i;
    logic        lookup_valid_o, hit_o, is_superpage_o;
    logic [31:0] paddr_o;
    logic [6:0]  perm_o;
    logic        fill_req_i, fill_superpage_i, fill_global_i;
    logic [19:0] fill_vpn_i;
    logic [21:0] fill_ppn_i;
    logic [6:0]  fill_perm_i;
    logic [8:0]  fill_asid_i;
    logic        flush_all_i, flush_vpn_i, flush_asid_i;
    logic [19:0] flush_vpn_addr_i;
    logic [8:0]  flush_asid_addr_i;

    int checks = 0;
    int errors = 0;

    tlb_assoc #(
        .ENTRIES (32),
        .ASID_W  (9)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .lookup_req_i      (lookup_req_i),
        .vaddr_i           (vaddr_i),
        .asid_i            (asid_i),
        .lookup_valid_o    (lookup_valid_o),
        .hit_o             (hit_o),
        .paddr_o           (paddr_o),
        .perm_o            (perm_o),
        .is_superpage_o    (is_superpage_o),
        .fill_req_i        (fill_req_i),
        .fill_vpn_i        (fill_vpn_i),
        .fill_ppn_i        (fill_ppn_i),
        .fill_perm_i       (fill_perm_i),
        .fill_superpage_i  (fill_superpage_i),
        .fill_global_i     (fill_global_i),
        .fill_asid_i       (fill_asid_i),
        .flush_all_i       (flush_all_i),
        .flush_vpn_i       (flush_vpn_i),
        .flush_asid_i      (flush_asid_i),
        .flush_vpn_addr_i  (flush_vpn_addr_i),
        .flush_asid_addr_i (flush_asid_addr_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] va;
        logic [8:0]  asid;
        logic        hit;
        logic [31:0] pa;
        logic [6:0]  perm;
        logic        sp;
    } vec_t;

    vec_t tbl [8];

    function automatic logic [41:0] outs();
        return {lookup_valid_o, hit_o, is_superpage_o, perm_o, paddr_o};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [41:0] got, input logic [41:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, exp);
        end
    endtask

    task automatic set_fill(input logic [19:0] vpn, input logic [21:0] ppn, input logic [6:0] perm,
                            input logic sp, input logic g, input logic [8:0] asid);
        fill_vpn_i       = vpn;
        fill_ppn_i       = ppn;
        fill_perm_i      = perm;
        fill_superpage_i = sp;
        fill_global_i    = g;
        fill_asid_i      = asid;
    endtask

    task automatic do_fill(input logic [19:0] vpn, input logic [21:0] ppn, input logic [6:0] perm,
                           input logic sp, input logic g, input logic [8:0] asid);
        set_fill(vpn, ppn, perm, sp, g, asid);
        fill_req_i = 1'b1;
        tick();
        fill_req_i = 1'b0;
    endtask

    task automatic do_flush(input logic all, input logic v, input logic a,
                            input logic [19:0] vaddr, input logic [8:0] aaddr);
        flush_all_i       = all;
        flush_vpn_i       = v;
        flush_asid_i      = a;
        flush_vpn_addr_i  = vaddr;
        flush_asid_addr_i = aaddr;
        tick();
        {flush_all_i, flush_vpn_i, flush_asid_i} = 3'b000;
    endtask

    task automatic lookup_chk(input string name, input logic [31:0] va, input logic [8:0] asid,
                              input logic h, input logic [31:0] pa, input logic [6:0] perm,
                              input logic sp);
        lookup_req_i = 1'b1;
        vaddr_i      = va;
        asid_i       = asid;
        tick();
        lookup_req_i = 1'b0;
        check(name, outs(), {1'b1, h, sp, perm, pa});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        lookup_req_i = 1'b0; vaddr_i = '0; asid_i = '0;
        fill_req_i = 1'b0;
        set_fill('0, '0, '0, 1'b0, 1'b0, '0);
        flush_all_i = 1'b0; flush_vpn_i = 1'b0; flush_asid_i = 1'b0;
        flush_vpn_addr_i = '0; flush_asid_addr_i = '0;

        tbl[0] = '{32'h12345ABC, 9'd1, 1'b1, 32'h80100ABC, 7'h0F, 1'b0};
        tbl[1] = '{32'h12345ABC, 9'd2, !ASID_EN, ASID_EN ? 32'h0 : 32'h80100ABC,
                   ASID_EN ? 7'h00 : 7'h0F, 1'b0};
        tbl[2] = '{32'h00001000, 9'd7, 1'b1, 32'h80200000, 7'h11, 1'b0};
        tbl[3] = '{32'h00002FFF, 9'd3, 1'b1, 32'h80300FFF, 7'h22, 1'b0};
        tbl[4] = '{32'h801FF456, 9'd1, 1'b1, 32'h901FF456, 7'h4B, 1'b1};
        tbl[5] = '{32'h84000000, 9'd1, 1'b0, 32'h0, 7'h00, 1'b0};
        tbl[6] = '{32'h12346000, 9'd1, 1'b0, 32'h0, 7'h00, 1'b0};
        tbl[7] = '{32'h00002000, 9'd4, !ASID_EN, ASID_EN ? 32'h0 : 32'h80300000,
                   ASID_EN ? 7'h00 : 7'h22, 1'b0};

        repeat (3) tick();
        check("reset_outputs", outs(), 42'h0);
        rst = 1'b0;
        tick();

        // ppn[21:20] of the third entry is set to show it is dropped.
        do_fill(20'h12345, 22'h080100, 7'h0F, 1'b0, 1'b0, 9'd1);
        do_fill(20'h00001, 22'h080200, 7'h11, 1'b0, 1'b1, 9'd0);
        do_fill(20'h00002, 22'h380300, 7'h22, 1'b0, 1'b0, 9'd3);
        do_fill(20'h80000, 22'h090000, 7'h4B, 1'b1, 1'b0, 9'd1);

        for (int i = 0; i < 8; i++) begin
            lookup_chk($sformatf("tbl%0d", i), tbl[i].va, tbl[i].asid, tbl[i].hit,
                       tbl[i].pa, tbl[i].perm, tbl[i].sp);
        end

        lookup_chk("hit_before_hold", 32'h00001234, 9'd0, 1'b1, 32'h80200234, 7'h11, 1'b0);
        tick();
        check("hold_no_lookup", outs(), {1'b0, 1'b1, 1'b0, 7'h11, 32'h80200234});

        do_flush(1'b0, 1'b0, 1'b1, 20'h0, 9'd3);
        lookup_chk("asid_flush_victim", 32'h00002000, 9'd3, 1'b0, 32'h0, 7'h00, 1'b0);
        lookup_chk("asid_flush_global", 32'h00001000, 9'd5, ASID_EN,
                   ASID_EN ? 32'h80200000 : 32'h0, ASID_EN ? 7'h11 : 7'h00, 1'b0);
        lookup_chk("asid_flush_other", 32'h12345ABC, 9'd1, ASID_EN,
                   ASID_EN ? 32'h80100ABC : 32'h0, ASID_EN ? 7'h0F : 7'h00, 1'b0);

        do_fill(20'h80000, 22'h090000, 7'h4B, 1'b1, 1'b0, 9'd1);
        lookup_chk("super_base", 32'h80000000, 9'd1, 1'b1, 32'h90000000, 7'h4B, 1'b1);
        do_flush(1'b0, 1'b1, 1'b0, 20'h80123, 9'd0);
        lookup_chk("super_vpn_flush", 32'h80000000, 9'd1, 1'b0, 32'h0, 7'h00, 1'b0);

        // Lookup alongside fill/flush sees the pre-edge contents.
        set_fill(20'h55555, 22'h005555, 7'h33, 1'b0, 1'b1, 9'd0);
        fill_req_i = 1'b1;
        lookup_req_i = 1'b1; vaddr_i = 32'h55555000; asid_i = 9'd0;
        tick();
        fill_req_i = 1'b0; lookup_req_i = 1'b0;
        check("lookup_with_fill", outs(), {1'b1, 1'b0, 1'b0, 7'h00, 32'h0});
        lookup_chk("after_fill", 32'h55555000, 9'd0, 1'b1, 32'h05555000, 7'h33, 1'b0);
        flush_vpn_i = 1'b1; flush_vpn_addr_i = 20'h55555;
        lookup_req_i = 1'b1; vaddr_i = 32'h55555000;
        tick();
        flush_vpn_i = 1'b0; lookup_req_i = 1'b0;
        check("lookup_with_flush", outs(), {1'b1, 1'b1, 1'b0, 7'h33, 32'h05555000});
        lookup_chk("after_flush", 32'h55555000, 9'd0, 1'b0, 32'h0, 7'h00, 1'b0);

        // flush_all wins over the selective flush and drops the same-cycle fill.
        do_fill(20'h66666, 22'h006666, 7'h01, 1'b0, 1'b1, 9'd0);
        set_fill(20'h77777, 22'h007777, 7'h02, 1'b0, 1'b1, 9'd0);
        fill_req_i = 1'b1;
        do_flush(1'b1, 1'b1, 1'b0, 20'h12345, 9'd0);
        fill_req_i = 1'b0;
        lookup_chk("flush_all_prec", 32'h66666000, 9'd0, 1'b0, 32'h0, 7'h00, 1'b0);
        lookup_chk("fill_dropped", 32'h77777000, 9'd0, 1'b0, 32'h0, 7'h00, 1'b0);

        do_flush(1'b1, 1'b0, 1'b0, 20'h0, 9'd0);
        for (int k = 0; k <= 32; k++) begin
            do_fill(20'h40000 + 20'(k), 22'h001000 + 22'(k), 7'h01, 1'b0, 1'b1, 9'd0);
        end
        lookup_chk("evict_first", 32'h40000000, 9'd0, 1'b0, 32'h0, 7'h00, 1'b0);
        lookup_chk("evict_last", 32'h40020000, 9'd0, 1'b1, 32'h01020000, 7'h01, 1'b0);
        lookup_chk("evict_second", 32'h40001123, 9'd0, 1'b1, 32'h01001123, 7'h01, 1'b0);
        do_fill(20'h40020, 22'h002222, 7'h05, 1'b0, 1'b1, 9'd0);
        lookup_chk("refill_new", 32'h40020000, 9'd0, 1'b1, 32'h02222000, 7'h05, 1'b0);
        lookup_chk("refill_no_evict", 32'h40001000, 9'd0, 1'b1, 32'h01001000, 7'h01, 1'b0);

        // Reset asserted while a lookup is pending.
        lookup_req_i = 1'b1; vaddr_i = 32'h40001000;
        #2;
        rst = 1'b1;
        #1;
        check("rst_async", outs(), 42'h0);
        tick();
        lookup_req_i = 1'b0;
        check("rst_no_valid", outs(), 42'h0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        lookup_chk("rst_cleared", 32'h40001000, 9'd0, 1'b0, 32'h0, 7'h00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tlb_assoc.md
TLB_ASSOC -- requirements
Module: tlb_assoc

Interface
REQ-001 Parameter ENTRIES, default 32, number of fully associative entries (power of two, 4..64).
REQ-002 Parameter ASID_W, default 9, ASID width.
REQ-003 clk  input  1  clock; single clock domain.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 lookup_req_i  input  1  lookup strobe.
REQ-006 vaddr_i  input  32  lookup virtual address.
REQ-007 asid_i  input  ASID_W  lookup ASID.
REQ-008 lookup_valid_o  output  1  result valid, one cycle after lookup_req_i.
REQ-009 hit_o  output  1  lookup hit.
REQ-010 paddr_o  output  32  translated address.
REQ-011 perm_o  output  7  stored permission bits.
REQ-012 is_superpage_o  output  1  hit entry is a 4 MiB page.
REQ-013 fill_req_i  input  1  install entry.
REQ-014 fill_vpn_i / fill_ppn_i / fill_perm_i  input  20 / 22 / 7  entry contents.
REQ-015 fill_superpage_i / fill_global_i  input  1 / 1  page size; global (ASID-independent).
REQ-016 fill_asid_i  input  ASID_W  entry ASID.
REQ-017 flush_all_i / flush_vpn_i / flush_asid_i  input  1 each  SFENCE.VMA selectors.
REQ-018 flush_vpn_addr_i / flush_asid_addr_i  input  20 / ASID_W  flush operands.

Function
REQ-019 Lookup SHALL be registered: outputs update on the clk edge after lookup_req_i; lookup_valid_o is high for exactly that cycle; other outputs hold their previous values while no lookup is issued.
REQ-020 Entry match: valid, and (global or asid equal), and (superpage ? vpn[19:10] equal : vpn[19:0] equal).
REQ-021 Hit on a 4 KiB entry: paddr_o = {ppn[19:0], vaddr[11:0]}; superpage: {ppn[19:10], vaddr[21:0]}; ppn[21:20] SHALL be dropped.
REQ-022 Miss: hit_o=0, paddr_o=0, perm_o=0, is_superpage_o=0.
REQ-023 Fill whose VPN/size/ASID matches an existing entry SHALL overwrite that entry (no duplicates); otherwise the lowest-index invalid entry; otherwise the entry at the round-robin victim pointer, which then increments mod ENTRIES.
REQ-024 Flush is single-cycle: flush_all clears every entry; vpn only clears matching VPN including globals; asid only clears non-global entries with that ASID; vpn+asid clears non-global entries matching both; superpage entries compare flush_vpn_addr_i[19:10].
REQ-025 flush_all_i SHALL take precedence over the selective flushes.
REQ-026 Flush and fill in the same cycle: flush applied, fill SHALL be dropped.
REQ-027 Lookup in the same cycle as fill or flush SHALL return the result from pre-edge contents.
REQ-028 Victim pointer SHALL be unchanged by flushes.

Reset
REQ-029 rst SHALL clear all valid bits, victim pointer to 0, and all outputs to 0, asynchronously; a fill or lookup in flight at reset is discarded.

Configuration
REQ-030 With TLB_ASID_EN defined: ASID storage, ASID compare and flush_asid_i behave as above.
REQ-031 Without TLB_ASID_EN: no ASID storage; every entry treated as global; flush_asid_i alone SHALL act as flush_all; flush_asid_i+flush_vpn_i acts as flush_vpn_i alone.

Structure
REQ-032 Shared package tlb_pkg SHALL hold the entry struct (valid, vpn, ppn, perm, superpage, global, asid), PERM_W=7, VPN_W=20, PPN_W=22.
REQ-033 One sub-module tlb_victim_sel SHALL compute the fill slot (first-invalid priority encoder, round-robin pointer).

Verification
REQ-034 Fill vpn 0x12345 ppn 0x80100 asid 1; lookup 0x12345ABC asid 1 -> next cycle valid, hit, paddr 0x80100ABC; same VA asid 2 -> miss.
REQ-035 Fill global vpn 0x00001 ppn 0x80200 and non-global 0x00002 asid 3; flush_asid 3 -> 0x00002000 misses, 0x00001000 hits with any asid.
REQ-036 Superpage fill vpn 0x80000 ppn 0x90000; lookup 0x801FF456 -> 0x901FF456; 0x84000000 -> miss; flush_vpn 0x80123 -> 0x80000000 misses.
REQ-037 Fill ENTRIES+1 distinct VPNs -> first-filled VPN misses, last hits; refill same VPN with new ppn -> new translation, no eviction.
REQ-038 Fill and flush_all same cycle -> all lookups miss; assert rst mid-lookup -> outputs 0 immediately, lookup_valid_o stays 0.
